regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the decode stage, next generation of the single-pair register file.
- Configurable data width, depth and read-port count; registered reads with a valid strobe.
- Reads and writes proceed in the same cycle; the single-port design made them mutually exclusive.
- After reset, a hardware clear sequencer zeroes every entry and reports busy until done.

Parameters:
- DATA_W, 32, bits per register entry.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to address 0 are discarded.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- rd_en  input  1  read enable, common to all ports.
- raddr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  output  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- rvalid  output  1  rdata updated this cycle.
- busy  output  1  clear sequence in progress; we and rd_en are ignored.

Behaviour:
- Reset (rst=1 at edge): state goes to CLEAR, clr_idx=0, rdata=0 (all ports), rvalid=0, busy=1. Array contents are not touched on the reset cycle itself.
- CLEAR state:
  - Each cycle writes 0 to entry clr_idx, then increments clr_idx.
  - After writing entry DEPTH-1, transitions to READY; busy falls in the same edge.
  - Duration is exactly DEPTH cycles after rst deasserts (32 with defaults).
  - we and rd_en are ignored; rvalid stays 0 and rdata stays 0.
- rst asserted during CLEAR: clr_idx restarts at 0, and the full DEPTH-cycle sweep repeats after rst drops.
- rst asserted during READY: returns to CLEAR, clears rdata and rvalid, and re-zeroes the whole array.
- READY state, write: if we=1, REG[waddr] <= wdata at the edge. If ZERO_REG=1 and waddr=0, the write is dropped.
- READY state, read:
  - If rd_en=1 at edge N, each port k loads rdata_k <= REG[raddr_k], and rvalid=1 after edge N.
  - Latency is 1 cycle; rvalid is a single-cycle pulse per accepted read.
  - With rd_en held high, rvalid stays high and reads stream every cycle.
  - If rd_en=0, rdata holds its last value and rvalid=0.
- Zero register: if ZERO_REG=1 and raddr_k=0, rdata_k=0 regardless of array content or bypass.
- Same-cycle read and write to the same address: result depends on REGFILE_WR_BYPASS_EN (see below).
- Multiple read ports may use identical addresses; each returns the same value independently.
- No wrap or overflow conditions exist: every address is in range by construction.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: when we=1, rd_en=1 and raddr_k==waddr in the same cycle, rdata_k takes wdata (write-first), except when the address is a zero register.
- Undefined: rdata_k takes the pre-write contents (read-first); the new value is visible from the next read onward.
- Either way the array is written identically.

Test Plan:
- Reset sequence: pulse rst 1 cycle, hold rd_en=1 and we=1 throughout. Required: busy=1 for exactly 32 cycles, rvalid=0 during that time, no write lands; the first read after busy falls returns 0 from every address.
- Basic write then read: write 0x8C123456 to r3 and 0xAD654321 to r5, then read raddr={5,3}. Required: one cycle later rdata port0=0x8C123456, port1=0xAD654321, rvalid=1 for one cycle.
- Zero register: write 0xFFFFFFFF to r0, then read r0 on both ports. Required: rdata=0 on both ports.
- Same-cycle hazard: r7 holds 0x13012345; in one cycle write 0x60000066 to r7 and read r7. Required: rdata=0x60000066 with REGFILE_WR_BYPASS_EN defined, 0x13012345 without; a read the following cycle returns 0x60000066 in both builds.
- Reset mid-clear: assert rst at clear cycle 10. Required: busy stays high for 32 cycles after the second rst deasserts, and all entries read 0 afterwards.
- Hold behaviour: read r3 (0x8C123456), then drop rd_en for 5 cycles while writing r3=0x1. Required: rdata stays 0x8C123456 and rvalid stays 0 for those 5 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with registered reads and a post-reset clear sweep.
// Optional macro REGFILE_WR_BYPASS_EN makes same-cycle read/write to one address write-first.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     rvalid,
    output logic                     busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_idx_q, clr_idx_d;
    logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;
    logic                     busy_q, busy_d;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        ra        = '0;
        rv        = '0;
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;

        if (state_q == ST_CLEAR) begin
            // The sweep owns the write port; user writes and reads are ignored.
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_READY;
                busy_d  = 1'b0;
            end
        end else begin
            mem_we = we && !((ZERO_REG != 0) && (waddr == '0));
            if (rd_en) begin
                rvalid_d = 1'b1;
                for (int k = 0; k < NUM_RD; k++) begin
                    ra = raddr[k*ADDR_W +: ADDR_W];
                    rv = mem_q[ra];
`ifdef REGFILE_WR_BYPASS_EN
                    if (we && (ra == waddr)) rv = wdata;
`endif
                    // Zero register wins over both array content and bypass.
                    if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
                    rdata_d[k*DATA_W +: DATA_W] = rv;
                end
            end
        end

        if (rst) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            rdata_d   = '0;
            rvalid_d  = 1'b0;
            busy_d    = 1'b1;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        rdata_q   <= rdata_d;
        rvalid_q  <= rvalid_d;
        busy_q    <= busy_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;

endmodule
